crp16_writeback_queue: RTL and testbench

- Collects completed results from two producers, the ALU and the memory unit, and serialises them onto the single write port of the CRP16 8x16-bit register file.
- Buffers results in a small in-order FIFO.
- Publishes a per-register pending mask so decode can stall on registers whose writes are still in flight.
- Sits directly upstream of the register file's write/write_sel/write_val inputs.

---
 rtl/crp16_writeback_queue.sv | 95 +++++++++
 tb/tb_crp16_writeback_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/crp16_writeback_queue.sv
// CRP16 writeback queue: merges ALU and memory-unit results into an in-order
// FIFO and drains one entry per cycle onto the register-file write port.
// Memory results are older than ALU results, so mem is enqueued ahead of alu
// when both are accepted on the same edge.
module crp16_writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [2:0]                 alu_sel,
  input  logic [15:0]                alu_val,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [2:0]                 mem_sel,
  input  logic [15:0]                mem_val,
  output logic                       mem_ready,
  output logic                       write,
  output logic [2:0]                 write_sel,
  output logic [15:0]                write_val,
  output logic [7:0]                 pending,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [2:0]    sel_q [DEPTH];
  logic [15:0]   val_q [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] free;
  logic          nonempty;
  logic          mem_acc;
  logic          alu_acc;

  // Free slots count the head being popped this cycle; readies and accepts follow.
  always_comb begin
    nonempty  = (count != '0);
    free      = CW'(DEPTH) - count + CW'(nonempty);
    mem_ready = !reset && (free >= CW'(1));
    alu_ready = !reset && ((free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid));
    mem_acc   = mem_valid && mem_ready;
    alu_acc   = alu_valid && alu_ready;
    alu_slot  = wr_ptr + PW'(mem_acc);
  end

  // Head entry drives the write port; zero when the queue is empty.
  always_comb begin
    write     = nonempty;
    write_sel = '0;
    write_val = '0;
    if (nonempty) begin
      write_sel = sel_q[rd_ptr];
      write_val = val_q[rd_ptr];
    end
  end

  // Pending mask: OR of one-hot destinations over occupied slots, head included.
  // A slot is occupied when its distance from rd_ptr (mod DEPTH) is below count.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ({1'b0, PW'(i) - rd_ptr} < count)
        pending[sel_q[i]] = 1'b1;
    end
  end

  // FIFO state: enqueue mem then alu at consecutive slots, pop head every non-empty cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sel_q[i] <= '0;
        val_q[i] <= '0;
      end
    end else begin
      if (mem_acc) begin
        sel_q[wr_ptr] <= mem_sel;
        val_q[wr_ptr] <= mem_val;
      end
      if (alu_acc) begin
        sel_q[alu_slot] <= alu_sel;
        val_q[alu_slot] <= alu_val;
      end
      wr_ptr <= wr_ptr + PW'(mem_acc) + PW'(alu_acc);
      rd_ptr <= rd_ptr + PW'(nonempty);
      count  <= count + CW'(mem_acc) + CW'(alu_acc) - CW'(nonempty);
    end
  end

endmodule

// File: tb/tb_crp16_writeback_queue.sv
module tb_crp16_writeback_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [2:0]  sel;
    logic [15:0] val;
  } ent_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic [2:0]    alu_sel, mem_sel;
  logic [15:0]   alu_val, mem_val;
  logic          alu_ready, mem_ready;
  logic          write;
  logic [2:0]    write_sel;
  logic [15:0]   write_val;
  logic [7:0]    pending;
  logic [CW-1:0] count;

  int   checks = 0;
  int   failures = 0;
  ent_t q[$];

  crp16_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_val(alu_val), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_val(mem_val), .mem_ready(mem_ready),
    .write(write), .write_sel(write_sel), .write_val(write_val),
    .pending(pending), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic mv, input logic [2:0] ms, input logic [15:0] mvl,
                      input logic av, input logic [2:0] as, input logic [15:0] avl,
                      output logic macc, output logic aacc);
    int            n;
    int            fr;
    logic          exp_mr, exp_ar;
    logic [7:0]    exp_pend;
    logic [2:0]    exp_sel;
    logic [15:0]   exp_val;
    reset = r; mem_valid = mv; mem_sel = ms; mem_val = mvl;
    alu_valid = av; alu_sel = as; alu_val = avl;
    #1;
    n  = q.size();
    fr = DEPTH - n + ((n != 0) ? 1 : 0);
    exp_mr = !r && (fr >= 1);
    exp_ar = !r && ((fr >= 2) || (fr >= 1 && !mv));
    exp_pend = '0;
    foreach (q[k]) exp_pend[q[k].sel] = 1'b1;
    exp_sel = (n != 0) ? q[0].sel : 3'd0;
    exp_val = (n != 0) ? q[0].val : 16'd0;
    chk("mem_ready", 32'(mem_ready), 32'(exp_mr));
    chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
    chk("write", 32'(write), 32'(n != 0));
    chk("write_sel", 32'(write_sel), 32'(exp_sel));
    chk("write_val", 32'(write_val), 32'(exp_val));
    chk("pending", 32'(pending), 32'(exp_pend));
    chk("count", 32'(count), 32'(n));
    macc = mv && exp_mr;
    aacc = av && exp_ar;
    @(posedge clock);
    if (r) begin
      q.delete();
    end else begin
      if (n != 0) void'(q.pop_front());
      if (macc) q.push_back(ent_t'({ms, mvl}));
      if (aacc) q.push_back(ent_t'({as, avl}));
    end
    #1;
  endtask

  task automatic idle(input int unsigned cycles);
    logic ma, aa;
    for (int unsigned i = 0; i < cycles; i++) step(1'b0, 1'b0, 3'd0, 16'd0, 1'b0, 3'd0, 16'd0, ma, aa);
  endtask

  initial begin
    logic        ma, aa;
    logic        pm_v, pa_v;
    logic [2:0]  pm_s, pa_s;
    logic [15:0] pm_d, pa_d;
    int          tries;

    reset = 1'b1; mem_valid = 1'b0; alu_valid = 1'b0;
    mem_sel = '0; alu_sel = '0; mem_val = '0; alu_val = '0;
    @(posedge clock); @(posedge clock); #1;

    chk("rst_write", 32'(write), 32'(0));
    chk("rst_write_sel", 32'(write_sel), 32'(0));
    chk("rst_write_val", 32'(write_val), 32'(0));
    chk("rst_pending", 32'(pending), 32'(0));
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_mem_ready", 32'(mem_ready), 32'(0));
    chk("rst_alu_ready", 32'(alu_ready), 32'(0));

    step(1'b1, 1'b1, 3'd0, 16'h1111, 1'b1, 3'd1, 16'h2222, ma, aa);
    idle(1);

    step(1'b0, 1'b0, 3'd0, 16'd0, 1'b1, 3'd3, 16'h1234, ma, aa);
    idle(2);

    step(1'b0, 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd1, 16'h5555, ma, aa);
    idle(3);

    pa_s = 3'd1; pa_d = 16'hA001;
    for (int unsigned i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 3'(2 * i), 16'(16'hC000 + i), 1'b1, pa_s, pa_d, ma, aa);
      if (aa) begin pa_s = pa_s + 3'd2; pa_d = pa_d + 16'd1; end
    end
    idle(6);

    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 3'(i), 16'(16'h0100 + i), 1'b1, 3'(i + 4), 16'(16'h0200 + i), ma, aa);
    tries = 0; aa = 1'b0;
    while (!aa && tries < 20) begin
      step(1'b0, (tries < 3), 3'd6, 16'(16'h0300 + tries), 1'b1, 3'd5, 16'hBEEF, ma, aa);
      tries++;
    end
    chk("bp_accept_bound", 32'(aa), 32'(1));
    idle(6);

    step(1'b0, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd4, 16'h4444, ma, aa);
    step(1'b0, 1'b1, 3'd6, 16'h6666, 1'b1, 3'd7, 16'h7777, ma, aa);
    step(1'b1, 1'b1, 3'd0, 16'h0F0F, 1'b1, 3'd1, 16'hF0F0, ma, aa);
    idle(3);

    idle(10);

    pm_v = 1'b0; pa_v = 1'b0; pm_s = '0; pa_s = '0; pm_d = '0; pa_d = '0;
    for (int unsigned i = 0; i < 400; i++) begin
      if (!pm_v) begin
        pm_v = ($urandom_range(0, 3) != 0);
        pm_s = 3'($urandom_range(0, 7));
        pm_d = 16'($urandom);
      end
      if (!pa_v) begin
        pa_v = ($urandom_range(0, 3) != 0);
        pa_s = 3'($urandom_range(0, 7));
        pa_d = 16'($urandom);
      end
      step(($urandom_range(0, 59) == 0), pm_v, pm_s, pm_d, pa_v, pa_s, pa_d, ma, aa);
      if (ma) pm_v = 1'b0;
      if (aa) pa_v = 1'b0;
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
